load_store_unit: RTL

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit_if.sv | 31 +++
 rtl/load_store_unit.sv | 85 ++++++++
 2 files changed

// File: rtl/load_store_unit_if.sv
// load_store_unit_if: request, data-memory and writeback signals of the load/store unit
//   req_*  : EX-stage request handshake (valid/ready) with store flag, address, data, rd
//   mem_*  : data memory address, write data, write enable, read data
//   wb_*   : writeback response handshake (valid/ready) with data, rd, write flag, fault
//   slave modport is the unit itself; master modport is the surrounding pipeline/memory
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_is_store;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [4:0]  req_rd;
  logic [31:0] mem_addr;
  logic [31:0] mem_din;
  logic        mem_we;
  logic [31:0] mem_dout;
  logic        wb_valid;
  logic        wb_ready;
  logic [31:0] wb_data;
  logic [4:0]  wb_rd;
  logic        wb_reg_write;
  logic        wb_fault;
  modport slave (
    input  req_valid, req_is_store, req_addr, req_wdata, req_rd, mem_dout, wb_ready,
    output req_ready, mem_addr, mem_din, mem_we, wb_valid, wb_data, wb_rd, wb_reg_write, wb_fault
  );
  modport master (
    output req_valid, req_is_store, req_addr, req_wdata, req_rd, mem_dout, wb_ready,
    input  req_ready, mem_addr, mem_din, mem_we, wb_valid, wb_data, wb_rd, wb_reg_write, wb_fault
  );
endinterface

// File: rtl/load_store_unit.sv
// load_store_unit: single-outstanding load/store FSM between EX stage, data memory and writeback
//   clk, rst_n  : clock, asynchronous active-low reset
//   bus         : load_store_unit_if.slave (request, memory and writeback signals)
//   fault_count : saturating count of out-of-range requests
module load_store_unit #(
  parameter int DEPTH  = 256,
  parameter int FCNT_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  load_store_unit_if.slave  bus,
  output logic [FCNT_W-1:0] fault_count
);
  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;
  state_t     state;
  logic [4:0] rd;
  // req_ready is a flop so it reads 0 during reset and rises on the first edge after release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      rd               <= '0;
      fault_count      <= '0;
      bus.req_ready    <= 1'b0;
      bus.mem_addr     <= '0;
      bus.mem_din      <= '0;
      bus.mem_we       <= 1'b0;
      bus.wb_valid     <= 1'b0;
      bus.wb_data      <= '0;
      bus.wb_rd        <= '0;
      bus.wb_reg_write <= 1'b0;
      bus.wb_fault     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid && bus.req_ready) begin
            bus.req_ready <= 1'b0;
            bus.mem_addr  <= bus.req_addr;
            bus.mem_din   <= bus.req_wdata;
            rd            <= bus.req_rd;
            if (bus.req_addr >= 32'(DEPTH)) begin
              state            <= RESP;
              bus.wb_valid     <= 1'b1;
              bus.wb_fault     <= 1'b1;
              bus.wb_reg_write <= 1'b0;
              bus.wb_data      <= '0;
              bus.wb_rd        <= bus.req_rd;
              if (~&fault_count) fault_count <= fault_count + 1'b1;
            end else if (bus.req_is_store) begin
              state      <= WRITE;
              bus.mem_we <= 1'b1;
            end else begin
              state <= READ;
            end
          end else begin
            bus.req_ready <= 1'b1;
          end
        end
        WRITE: begin
          state            <= RESP;
          bus.mem_we       <= 1'b0;
          bus.wb_valid     <= 1'b1;
          bus.wb_fault     <= 1'b0;
          bus.wb_reg_write <= 1'b0;
          bus.wb_data      <= '0;
          bus.wb_rd        <= rd;
        end
        READ: begin
          state            <= RESP;
          bus.wb_valid     <= 1'b1;
          bus.wb_fault     <= 1'b0;
          bus.wb_reg_write <= rd != 5'd0;
          bus.wb_data      <= bus.mem_dout;
          bus.wb_rd        <= rd;
        end
        default: begin
          if (bus.wb_ready) begin
            state         <= IDLE;
            bus.wb_valid  <= 1'b0;
            bus.req_ready <= 1'b1;
          end
        end
      endcase
    end
  end
endmodule
